pulse_sequencer: RTL and testbench

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

---
 rtl/pulse_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_pulse_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - profile-table driven pulse sequencer for a pulse generator
//
// Purpose:
//   Holds a small table of {high-time, low-time, repeat, last} entries and walks
//   a downstream pulse generator through them. It counts generator periods
//   (rising edges of gen_cycle) and hands the generator new time words once an
//   entry has run its repeat count.
//
// Optional feature:
//   PULSE_SEQ_LOOP_EN - when defined, loop_mode=1 makes a completing "last" entry
//                       wrap back to entry 0 instead of finishing.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - asynchronous active-low reset
//   cfg_valid  - table write request
//   cfg_ready  - table write accepted this cycle (IDLE only)
//   cfg_addr   - table entry index
//   cfg_tph    - high-time word, stored unmodified
//   cfg_tpl    - low-time word, stored unmodified
//   cfg_rep    - periods per entry (0 treated as 1)
//   cfg_last   - entry terminates the sequence
//   start      - run request (honoured in IDLE only)
//   stop       - abort request (overrides everything else)
//   loop_mode  - wrap after the last entry (PULSE_SEQ_LOOP_EN builds only)
//   gen_cycle  - generator signal_cycle, high at start of each period
//   gen_reset  - synchronous reset to the generator
//   tph, tpl   - time words to the generator
//   busy       - sequence active (LOAD, RUN, DRAIN)
//   done       - one-cycle completion pulse
//   cur_entry  - entry currently driving tph/tpl

module pulse_sequencer #(
  parameter int NUM_ENTRIES = 4,
  parameter int REP_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_addr,
  input  logic [15:0]                    cfg_tph,
  input  logic [15:0]                    cfg_tpl,
  input  logic [REP_W-1:0]               cfg_rep,
  input  logic                           cfg_last,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           loop_mode,
  input  logic                           gen_cycle,
  output logic                           gen_reset,
  output logic [15:0]                    tph,
  output logic [15:0]                    tpl,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_ENTRIES)-1:0] cur_entry
);

  localparam int AW = $clog2(NUM_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state, state_next;

  // Profile table; deliberately not reset so a configuration survives reset.
  logic [15:0]      tph_mem  [NUM_ENTRIES];
  logic [15:0]      tpl_mem  [NUM_ENTRIES];
  logic [REP_W-1:0] rep_mem  [NUM_ENTRIES];
  logic             last_mem [NUM_ENTRIES];

  logic [REP_W-1:0] rep_cnt;
  logic             load_cnt;
  logic             gen_cycle_q;
  logic             period_start;

  logic             load_en;
  logic [AW-1:0]    load_idx;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             loop_go;

  logic [REP_W-1:0] rep_eff;
  logic [REP_W:0]   cnt_plus;
  logic             entry_done;

  // ---------------------------------------------------------------------------
  // Table write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_ready) begin
      tph_mem[cfg_addr]  <= cfg_tph;
      tpl_mem[cfg_addr]  <= cfg_tpl;
      rep_mem[cfg_addr]  <= cfg_rep;
      last_mem[cfg_addr] <= cfg_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Period detection and entry completion
  // ---------------------------------------------------------------------------
  // The edge-detect register is held low during LOAD so that a gen_cycle that
  // is already high when RUN begins still counts as the first period.
  assign period_start = gen_cycle & ~gen_cycle_q;

  // A repeat count of 0 behaves as 1 so every entry gets at least one period.
  assign rep_eff    = (rep_mem[cur_entry] == '0) ? {{(REP_W-1){1'b0}}, 1'b1}
                                                 : rep_mem[cur_entry];
  assign cnt_plus   = {1'b0, rep_cnt} + {{REP_W{1'b0}}, 1'b1};
  assign entry_done = (cnt_plus >= {1'b0, rep_eff});

`ifdef PULSE_SEQ_LOOP_EN
  assign loop_go = loop_mode;
`else
  logic unused_loop_mode;
  assign unused_loop_mode = loop_mode;
  assign loop_go          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      tph         <= 16'h0000;
      tpl         <= 16'h0000;
      cur_entry   <= '0;
      rep_cnt     <= '0;
      load_cnt    <= 1'b0;
      gen_cycle_q <= 1'b0;
    end else begin
      state       <= state_next;
      gen_cycle_q <= (state == S_LOAD) ? 1'b0 : gen_cycle;
      // Toggles once per LOAD cycle: 0 on the first, 1 on the second.
      load_cnt    <= (state == S_LOAD) ? ~load_cnt : 1'b0;

      if (load_en) begin
        tph       <= tph_mem[load_idx];
        tpl       <= tpl_mem[load_idx];
        cur_entry <= load_idx;
      end

      if (cnt_clr) begin
        rep_cnt <= '0;
      end else if (cnt_inc) begin
        rep_cnt <= cnt_plus[REP_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    load_idx   = '0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_next = S_LOAD;
          load_en    = 1'b1;
          load_idx   = '0;
          cnt_clr    = 1'b1;
        end
      end

      S_LOAD: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (load_cnt) begin
          state_next = S_RUN;
        end
      end

      S_RUN: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (period_start) begin
          if (entry_done) begin
            cnt_clr = 1'b1;
            if (!last_mem[cur_entry]) begin
              // Power-of-two depth: the increment wraps to 0 naturally.
              load_en  = 1'b1;
              load_idx = cur_entry + 1'b1;
            end else if (loop_go) begin
              load_en  = 1'b1;
              load_idx = '0;
            end else begin
              // Leave tph/tpl alone so the generator finishes its final period.
              state_next = S_DRAIN;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (period_start) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  assign cfg_ready = (state == S_IDLE);
  assign gen_reset = (state == S_IDLE) || (state == S_LOAD) || (state == S_DONE);
  assign busy      = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - self-checking bench for pulse_sequencer

module tb_pulse_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_tph;
  logic [15:0] cfg_tpl;
  logic [7:0]  cfg_rep;
  logic        cfg_last;
  logic        start;
  logic        stop;
  logic        loop_mode;
  logic        gen_cycle;
  logic        gen_reset;
  logic [15:0] tph;
  logic [15:0] tpl;
  logic        busy;
  logic        done;
  logic [1:0]  cur_entry;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_sequencer #(
    .NUM_ENTRIES(4),
    .REP_W      (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_tph   (cfg_tph),
    .cfg_tpl   (cfg_tpl),
    .cfg_rep   (cfg_rep),
    .cfg_last  (cfg_last),
    .start     (start),
    .stop      (stop),
    .loop_mode (loop_mode),
    .gen_cycle (gen_cycle),
    .gen_reset (gen_reset),
    .tph       (tph),
    .tpl       (tpl),
    .busy      (busy),
    .done      (done),
    .cur_entry (cur_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        gc;
    logic        exp_gr;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_ready;
    logic [1:0]  exp_cur;
    logic [15:0] exp_tph;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rise.
  task automatic step(input logic s, input logic p, input logic gc);
    @(negedge clk);
    start     = s;
    stop      = p;
    gen_cycle = gc;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] h, input logic [15:0] l,
                    input logic [7:0] r, input logic last);
    @(negedge clk);
    cfg_addr  = a;
    cfg_tph   = h;
    cfg_tpl   = l;
    cfg_rep   = r;
    cfg_last  = last;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    // start, stop, gc | gen_reset, busy, done, cfg_ready, cur_entry, tph
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0102}; // LOAD 1
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0102}; // LOAD 2
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0102}; // RUN
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0102}; // e0 period 1
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0102};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0005}; // e0 period 2 -> e1
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0005};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0005}; // e1 period -> DRAIN
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0005};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0005}; // DONE
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0005}; // IDLE

    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = 2'd0;
    cfg_tph   = 16'h0;
    cfg_tpl   = 16'h0;
    cfg_rep   = 8'd0;
    cfg_last  = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    loop_mode = 1'b0;
    gen_cycle = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset gen_reset", 32'(gen_reset), 32'h1);
    check("reset busy",      32'(busy),      32'h0);
    check("reset done",      32'(done),      32'h0);
    check("reset tph",       32'(tph),       32'h0);
    check("reset tpl",       32'(tpl),       32'h0);
    check("reset cur_entry", 32'(cur_entry), 32'h0);
    check("reset cfg_ready", 32'(cfg_ready), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic two-entry sequence
    wr(2'd0, 16'h0102, 16'h0103, 8'd2, 1'b0);
    wr(2'd1, 16'h0005, 16'h0005, 8'd1, 1'b1);
    wr(2'd2, 16'h2222, 16'h2223, 8'd1, 1'b0);
    wr(2'd3, 16'h3333, 16'h3334, 8'd1, 1'b0);

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].start, vecs[i].stop, vecs[i].gc);
      check($sformatf("v%0d gen_reset", i), 32'(gen_reset), 32'(vecs[i].exp_gr));
      check($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].exp_busy));
      check($sformatf("v%0d done", i),      32'(done),      32'(vecs[i].exp_done));
      check($sformatf("v%0d cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d cur_entry", i), 32'(cur_entry), 32'(vecs[i].exp_cur));
      check($sformatf("v%0d tph", i),       32'(tph),       32'(vecs[i].exp_tph));
    end

    // Table writes blocked while running, stop in entry 1 overriding a period start
    step(1'b1, 1'b0, 1'b0);
    check("A load tpl", 32'(tpl), 32'h0103);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cfg_addr  = 2'd0;
    cfg_tph   = 16'hBEEF;
    cfg_tpl   = 16'hBEEF;
    cfg_rep   = 8'd7;
    cfg_last  = 1'b1;
    cfg_valid = 1'b1;
    check("A cfg_ready run", 32'(cfg_ready), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("A cfg_ready run2", 32'(cfg_ready), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("A cur_entry e1", 32'(cur_entry), 32'h1);
    cfg_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("A stop busy",      32'(busy),      32'h0);
    check("A stop gen_reset", 32'(gen_reset), 32'h1);
    check("A stop done",      32'(done),      32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("A after stop done", 32'(done), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    check("A table tph kept", 32'(tph), 32'h0102);
    check("A table tpl kept", 32'(tpl), 32'h0103);
    step(1'b0, 1'b1, 1'b0);
    check("A stop in LOAD busy", 32'(busy), 32'h0);

    // rep=0 single period, gen_cycle high across LOAD, index wrap
    wr(2'd0, 16'h0A0A, 16'h0B0B, 8'd0, 1'b0);
    wr(2'd1, 16'h1111, 16'h1112, 8'd1, 1'b0);
    wr(2'd2, 16'h2222, 16'h2223, 8'd1, 1'b0);
    wr(2'd3, 16'h3333, 16'h3334, 8'd1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("B run cur_entry", 32'(cur_entry), 32'h0);
    check("B run gen_reset", 32'(gen_reset), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("B rep0 advance", 32'(cur_entry), 32'h1);
    check("B rep0 tph",     32'(tph),       32'h1111);
    begin
      logic [1:0] exp_seq [3];
      exp_seq[0] = 2'd2;
      exp_seq[1] = 2'd3;
      exp_seq[2] = 2'd0;
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check($sformatf("B seq%0d cur_entry", k), 32'(cur_entry), 32'(exp_seq[k]));
      end
    end
    check("B wrap tph", 32'(tph), 32'h0A0A);
    check("B wrap busy", 32'(busy), 32'h1);
    step(1'b0, 1'b1, 1'b0);

    // Reset during DRAIN
    wr(2'd0, 16'h0102, 16'h0103, 8'd2, 1'b0);
    wr(2'd1, 16'h0005, 16'h0005, 8'd1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("C drain busy",      32'(busy),      32'h1);
    check("C drain gen_reset", 32'(gen_reset), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("C rst tph",       32'(tph),       32'h0);
    check("C rst tpl",       32'(tpl),       32'h0);
    check("C rst cur_entry", 32'(cur_entry), 32'h0);
    check("C rst gen_reset", 32'(gen_reset), 32'h1);
    check("C rst busy",      32'(busy),      32'h0);
    check("C rst done",      32'(done),      32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'(k % 2));
      check($sformatf("C post rst done%0d", k), 32'(done), 32'h0);
    end
    step(1'b1, 1'b0, 1'b0);
    check("C table survives reset", 32'(tph), 32'h0102);
    step(1'b0, 1'b1, 1'b0);

    // loop_mode
    wr(2'd0, 16'h0A00, 16'h0A01, 8'd1, 1'b0);
    wr(2'd1, 16'h0B00, 16'h0B01, 8'd1, 1'b1);
    loop_mode = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("D run cur_entry", 32'(cur_entry), 32'h0);
`ifdef PULSE_SEQ_LOOP_EN
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1);
      check($sformatf("D loop%0d cur_entry", k), 32'(cur_entry), 32'((k % 2 == 0) ? 1 : 0));
      check($sformatf("D loop%0d busy", k),      32'(busy),      32'h1);
      check($sformatf("D loop%0d done", k),      32'(done),      32'h0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    check("D loop stop busy", 32'(busy), 32'h0);
    check("D loop stop done", 32'(done), 32'h0);
`else
    step(1'b0, 1'b0, 1'b1);
    check("D noloop cur_entry", 32'(cur_entry), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("D noloop drain cur", 32'(cur_entry), 32'h1);
    check("D noloop drain busy", 32'(busy), 32'h1);
    check("D noloop drain done", 32'(done), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("D noloop done", 32'(done), 32'h1);
    check("D noloop done busy", 32'(busy), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("D noloop done clears", 32'(done), 32'h0);
`endif
    loop_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
